comp_mul_acc: RTL and testbench

- Downstream stage of the complex multiplier: consumes its 17-bit signed product stream (real/imag plus valid strobe) and accumulates N consecutive products into one complex sum.
- Forms the dot-product / correlation tail of the complex datapath.
- Emits one registered result with a one-cycle valid pulse per group of N accepted products.
- Supports back-to-back groups with no dead cycles.

---
 rtl/comp_mul_acc_if.sv | 25 ++
 rtl/comp_mul_acc.sv | 102 ++++++++++
 tb/tb_comp_mul_acc.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/comp_mul_acc_if.sv
// Product-stream bus between the complex multiplier and its accumulator.
// Inputs i_*: signed product, valid and clear; outputs o_*: sum, pulse, busy.
interface comp_mul_acc_if #(
    parameter int IW = 17,
    parameter int OW = 19
);
    logic signed [IW-1:0] i_r;
    logic signed [IW-1:0] i_i;
    logic                 i_en;
    logic                 i_clr;
    logic signed [OW-1:0] o_r;
    logic signed [OW-1:0] o_i;
    logic                 o_en;
    logic                 o_busy;

    modport master (
        output i_r, i_i, i_en, i_clr,
        input  o_r, o_i, o_en, o_busy
    );

    modport slave (
        input  i_r, i_i, i_en, i_clr,
        output o_r, o_i, o_en, o_busy
    );
endinterface

// File: rtl/comp_mul_acc.sv
// Complex multiply-accumulate tail: sums N consecutive complex products.
// Ports: clk, rst (sync, active low), bus (slave: i_r/i_i/i_en/i_clr in,
// o_r/o_i sum, o_en one-cycle result pulse, o_busy partial group held).
module comp_mul_acc #(
    parameter int N  = 4,
    parameter int IW = 17,
    parameter int CW = 2,
    parameter int OW = 19
) (
    input logic           clk,
    input logic           rst,
    comp_mul_acc_if.slave bus
);
    typedef enum logic {IDLE, ACC} state_t;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t               state_q, state_d;
    logic signed [OW-1:0] acc_r_q, acc_r_d;
    logic signed [OW-1:0] acc_i_q, acc_i_d;
    logic        [CW-1:0] cnt_q, cnt_d;
    logic signed [OW-1:0] o_r_q, o_r_d;
    logic signed [OW-1:0] o_i_q, o_i_d;
    logic                 o_en_q, o_en_d;
    logic                 busy_q, busy_d;

    logic signed [OW-1:0] in_r, in_i;
    logic signed [OW-1:0] sum_r, sum_i;

    assign in_r  = {{(OW-IW){bus.i_r[IW-1]}}, bus.i_r};
    assign in_i  = {{(OW-IW){bus.i_i[IW-1]}}, bus.i_i};
    assign sum_r = acc_r_q + in_r;
    assign sum_i = acc_i_q + in_i;

    // Input data only reaches the accumulator through the i_en branches,
    // so garbage on idle cycles never disturbs it.
    always_comb begin
        state_d = state_q;
        acc_r_d = acc_r_q;
        acc_i_d = acc_i_q;
        cnt_d   = cnt_q;
        o_r_d   = o_r_q;
        o_i_d   = o_i_q;
        o_en_d  = 1'b0;
        if (bus.i_clr) begin
            if (bus.i_en) begin
                acc_r_d = in_r;
                acc_i_d = in_i;
                cnt_d   = CW'(1);
                state_d = ACC;
            end else begin
                acc_r_d = '0;
                acc_i_d = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        end else if (bus.i_en) begin
            if (cnt_q == LAST) begin
                o_r_d   = sum_r;
                o_i_d   = sum_i;
                o_en_d  = 1'b1;
                acc_r_d = '0;
                acc_i_d = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                acc_r_d = sum_r;
                acc_i_d = sum_i;
                cnt_d   = cnt_q + CW'(1);
                state_d = ACC;
            end
        end
        busy_d = (state_d == ACC);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_r_q <= '0;
            acc_i_q <= '0;
            cnt_q   <= '0;
            o_r_q   <= '0;
            o_i_q   <= '0;
            o_en_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_r_q <= acc_r_d;
            acc_i_q <= acc_i_d;
            cnt_q   <= cnt_d;
            o_r_q   <= o_r_d;
            o_i_q   <= o_i_d;
            o_en_q  <= o_en_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.o_r    = o_r_q;
    assign bus.o_i    = o_i_q;
    assign bus.o_en   = o_en_q;
    assign bus.o_busy = busy_q;
endmodule

// File: tb/tb_comp_mul_acc.sv
// Bench for comp_mul_acc: vector table, directed corners, random vs model.
// Drives an N=4 instance (queue model) and an N=2 instance (directed).
module tb_comp_mul_acc;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    comp_mul_acc_if #(.IW(17), .OW(19)) b4 ();
    comp_mul_acc_if #(.IW(17), .OW(18)) b2 ();

    comp_mul_acc #(.N(4), .IW(17), .CW(2), .OW(19)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    comp_mul_acc #(.N(2), .IW(17), .CW(1), .OW(18)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    // Model: the accepted samples of the open group, as plain integers.
    int mq_r[$];
    int mq_i[$];
    int m_r = 0, m_i = 0, m_en = 0, m_busy = 0;

    typedef struct {
        int en; int clr; int r; int i;
        int x_en; int x_r; int x_i; int x_busy;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic model_step();
        int sr, si;
        m_en = 0;
        if (!rst) begin
            mq_r.delete(); mq_i.delete();
            m_r = 0; m_i = 0;
        end else if (b4.i_clr) begin
            mq_r.delete(); mq_i.delete();
            if (b4.i_en) begin
                mq_r.push_back(int'(b4.i_r));
                mq_i.push_back(int'(b4.i_i));
            end
        end else if (b4.i_en) begin
            mq_r.push_back(int'(b4.i_r));
            mq_i.push_back(int'(b4.i_i));
            if (mq_r.size() == N) begin
                sr = 0; si = 0;
                foreach (mq_r[k]) begin
                    sr += mq_r[k];
                    si += mq_i[k];
                end
                m_r = sr; m_i = si; m_en = 1;
                mq_r.delete(); mq_i.delete();
            end
        end
        m_busy = (mq_r.size() != 0) ? 1 : 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        chk("mdl_r", int'(b4.o_r), m_r);
        chk("mdl_i", int'(b4.o_i), m_i);
        chk("mdl_en", int'(b4.o_en), m_en);
        chk("mdl_busy", int'(b4.o_busy), m_busy);
    endtask

    task automatic drv4(input int en, input int clr, input int r, input int i);
        b4.i_en  = en[0];
        b4.i_clr = clr[0];
        b4.i_r   = 17'(r);
        b4.i_i   = 17'(i);
    endtask

    task automatic add(input int en, input int clr, input int r, input int i,
                       input int xe, input int xr, input int xi, input int xb);
        vec_t v;
        v.en = en; v.clr = clr; v.r = r; v.i = i;
        v.x_en = xe; v.x_r = xr; v.x_i = xi; v.x_busy = xb;
        tbl.push_back(v);
    endtask

    initial begin
        drv4(0, 0, 0, 0);
        b2.i_en = 1'b0; b2.i_clr = 1'b0;
        b2.i_r = '0; b2.i_i = '0;

        // Back-to-back groups of (1,-1).
        for (int k = 0; k < 8; k++)
            add(1, 0, 1, -1, (k % 4 == 3) ? 1 : 0,
                (k < 3) ? 0 : 4, (k < 3) ? 0 : -4, (k % 4 == 3) ? 0 : 1);
        // Full-scale, no wrap.
        for (int k = 0; k < 4; k++)
            add(1, 0, -65536, 65535, (k == 3) ? 1 : 0,
                (k == 3) ? -262144 : 4, (k == 3) ? 262140 : -4,
                (k == 3) ? 0 : 1);
        // Clear with a sample restarts the group.
        add(1, 0, 5, 5, 0, -262144, 262140, 1);
        add(1, 0, 5, 5, 0, -262144, 262140, 1);
        add(1, 1, 1, 1, 0, -262144, 262140, 1);
        add(1, 0, 1, 1, 0, -262144, 262140, 1);
        add(1, 0, 1, 1, 0, -262144, 262140, 1);
        add(1, 0, 1, 1, 1, 4, 4, 0);
        // Clear on the would-be Nth sample suppresses the result.
        add(1, 0, 1, 1, 0, 4, 4, 1);
        add(1, 0, 1, 1, 0, 4, 4, 1);
        add(1, 0, 1, 1, 0, 4, 4, 1);
        add(1, 1, 9, 9, 0, 4, 4, 1);
        add(1, 0, 1, 1, 0, 4, 4, 1);
        add(1, 0, 1, 1, 0, 4, 4, 1);
        add(1, 0, 1, 1, 1, 12, 12, 0);
        add(0, 0, 0, 0, 0, 12, 12, 0);

        // Reset held two cycles with live samples.
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drv4(1, 0, int'($urandom_range(0, 131071)), int'($urandom_range(0, 131071)));
            tick();
        end
        chk("rst_r", int'(b4.o_r), 0);
        chk("rst_i", int'(b4.o_i), 0);
        chk("rst_en", int'(b4.o_en), 0);
        chk("rst_busy", int'(b4.o_busy), 0);
        rst = 1'b1;

        foreach (tbl[k]) begin
            drv4(tbl[k].en, tbl[k].clr, tbl[k].r, tbl[k].i);
            tick();
            chk($sformatf("tbl%0d_en", k), int'(b4.o_en), tbl[k].x_en);
            chk($sformatf("tbl%0d_r", k), int'(b4.o_r), tbl[k].x_r);
            chk($sformatf("tbl%0d_i", k), int'(b4.o_i), tbl[k].x_i);
            chk($sformatf("tbl%0d_busy", k), int'(b4.o_busy), tbl[k].x_busy);
        end

        // Gaps inside a group.
        for (int k = 0; k < 3; k++) begin
            drv4(1, 0, 2, 3); tick();
        end
        for (int k = 0; k < 5; k++) begin
            drv4(0, 0, 77, 77); tick();
            chk("gap_en", int'(b4.o_en), 0);
            chk("gap_busy", int'(b4.o_busy), 1);
        end
        drv4(1, 0, 2, 3); tick();
        chk("gap_fin_en", int'(b4.o_en), 1);
        chk("gap_fin_r", int'(b4.o_r), 8);
        chk("gap_fin_i", int'(b4.o_i), 12);
        for (int k = 0; k < 3; k++) begin
            drv4(0, 0, 0, 0); tick();
            chk("hold_en", int'(b4.o_en), 0);
            chk("hold_r", int'(b4.o_r), 8);
            chk("hold_i", int'(b4.o_i), 12);
        end

        // Clear alone mid-group.
        drv4(1, 0, 6, 6); tick();
        drv4(1, 0, 6, 6); tick();
        chk("clr_pre_busy", int'(b4.o_busy), 1);
        drv4(0, 1, 0, 0); tick();
        chk("clr_busy", int'(b4.o_busy), 0);
        chk("clr_en", int'(b4.o_en), 0);
        chk("clr_r", int'(b4.o_r), 8);
        drv4(0, 0, 0, 0); tick();
        chk("clr_en2", int'(b4.o_en), 0);

        // Reset after three samples.
        for (int k = 0; k < 3; k++) begin
            drv4(1, 0, 4, 4); tick();
        end
        rst = 1'b0;
        drv4(1, 0, 4, 4); tick();
        chk("rmid_en", int'(b4.o_en), 0);
        chk("rmid_busy", int'(b4.o_busy), 0);
        chk("rmid_r", int'(b4.o_r), 0);
        rst = 1'b1;
        drv4(1, 0, 4, 4); tick();
        chk("rmid_en2", int'(b4.o_en), 0);
        chk("rmid_busy2", int'(b4.o_busy), 1);
        drv4(0, 1, 0, 0); tick();

        // N=2 instance.
        b2.i_en = 1'b1; b2.i_r = 17'sd7; b2.i_i = 17'sd9;
        tick();
        chk("n2_busy", int'(b2.o_busy), 1);
        chk("n2_en0", int'(b2.o_en), 0);
        b2.i_r = -17'sd8; b2.i_i = 17'sd38;
        tick();
        chk("n2_en", int'(b2.o_en), 1);
        chk("n2_r", int'(b2.o_r), -1);
        chk("n2_i", int'(b2.o_i), 47);
        chk("n2_busy1", int'(b2.o_busy), 0);
        b2.i_en = 1'b0;
        tick();
        chk("n2_en_off", int'(b2.o_en), 0);
        chk("n2_hold", int'(b2.o_r), -1);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
            drv4(($urandom_range(0, 3) != 0) ? 1 : 0,
                 ($urandom_range(0, 15) == 0) ? 1 : 0,
                 int'($urandom_range(0, 131071)),
                 int'($urandom_range(0, 131071)));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
